max_pool_stream: RTL and testbench

- Upstream feeder of the first dense layer.
- Accepts a 28x28 unsigned 8-bit grayscale image as a raster pixel stream, one pixel per accepted cycle.
- Performs 2x2 stride-2 pooling using a single-row line buffer.
- Presents the 14x14 result as a parallel array of signed 16-bit values in range 0..127, indexed row-major, directly driving the dense layer's pooled-image input. Asserts a done flag when the frame is complete.

---
 rtl/max_pool_stream.sv | 115 +++++++++++
 tb/tb_max_pool_stream.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 pooling of a raster image into a parallel pooled array.
// Define POOL_AVG_EN to build average pooling (mean/2) instead of max pooling (max/2).
module max_pool_stream #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int PIX_W = 8,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [PIX_W-1:0]        pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic signed [OUT_W-1:0] pooled_img [0:(IMG_W/2)*(IMG_H/2)-1],
   output logic                    pool_done
);

   localparam int N_OUT  = (IMG_W/2)*(IMG_H/2);
   localparam int HALF_W = IMG_W/2;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);
   localparam int IDX_W  = $clog2(N_OUT);
`ifdef POOL_AVG_EN
   localparam int LB_W   = PIX_W + 2;
   localparam int SHIFT  = 3;
`else
   localparam int LB_W   = PIX_W;
   localparam int SHIFT  = 1;
`endif

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t               state, state_next;
   logic [ROW_W-1:0]     row;
   logic [COL_W-1:0]     col;
   logic [LB_W-1:0]      lb [0:HALF_W-1];
   logic [COL_W-2:0]     k;
   logic [LB_W-1:0]      pix_ext;
   logic [LB_W-1:0]      merged;
   logic [LB_W-1:0]      pool_val;
   logic [IDX_W-1:0]     out_idx;
   logic                 take;
   logic                 last_pix;

   // A pixel arriving on the same cycle enable drops is discarded along with the frame.
   assign take     = (state == STREAM) && pix_valid && enable;
   assign last_pix = take && (row == ROW_W'(IMG_H-1)) && (col == COL_W'(IMG_W-1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = STREAM;
         STREAM:  if (!enable) state_next = IDLE;
                  else if (last_pix) state_next = DONE;
         DONE:    if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pix_ready = (state == STREAM);
      pool_done = (state == DONE);
   end

   always_comb begin
      k        = col[COL_W-1:1];
      pix_ext  = LB_W'(pix_in);
`ifdef POOL_AVG_EN
      merged   = lb[k] + pix_ext;
`else
      merged   = (pix_ext > lb[k]) ? pix_ext : lb[k];
`endif
      pool_val = merged >> SHIFT;
      out_idx  = IDX_W'(row >> 1) * IDX_W'(HALF_W) + IDX_W'(k);
   end

   always_ff @(posedge clk) begin
      if (reset || state_next != STREAM) begin
         row <= '0;
         col <= '0;
      end else if (take) begin
         if (col == COL_W'(IMG_W-1)) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // The top-left pixel of each window overwrites its entry, so stale contents never leak.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < HALF_W; i++) lb[i] <= '0;
      end else if (take) begin
         if (!row[0] && !col[0])     lb[k] <= pix_ext;
         else if (!(row[0] && col[0])) lb[k] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_OUT; i++) pooled_img[i] <= '0;
      end else if (take && row[0] && col[0]) begin
         pooled_img[out_idx] <= signed'(OUT_W'(pool_val));
      end
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed and table-driven bench for max_pool_stream; expectations follow POOL_AVG_EN when defined.
module tb_max_pool_stream;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int N_PIX = IMG_W*IMG_H;
   localparam int N_OUT = (IMG_W/2)*(IMG_H/2);

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [7:0]        pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic signed [15:0] pooled [0:N_OUT-1];
   logic              pool_done;

   int n_cmp = 0;
   int n_bad = 0;

   int unsigned img     [0:N_PIX-1];
   int          exp_img [0:N_OUT-1];

   typedef struct {
      int unsigned p0, p1, p2, p3;
      int r, c;
      int exp_max, exp_avg;
   } vec_t;
   vec_t vecs [6];

   max_pool_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(8), .OUT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pix_in(pix_in),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pooled_img(pooled),
      .pool_done(pool_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_array(input string name);
      for (int i = 0; i < N_OUT; i++)
         check($sformatf("%s[%0d]", name, i), int'(pooled[i]), exp_img[i]);
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Independent reference: pool directly over the stored image.
   task automatic model();
      for (int r = 0; r < IMG_H/2; r++)
         for (int c = 0; c < IMG_W/2; c++) begin
            int a, b, d, e;
            a = int'(img[(2*r)*IMG_W + 2*c]);
            b = int'(img[(2*r)*IMG_W + 2*c + 1]);
            d = int'(img[(2*r+1)*IMG_W + 2*c]);
            e = int'(img[(2*r+1)*IMG_W + 2*c + 1]);
`ifdef POOL_AVG_EN
            exp_img[r*(IMG_W/2)+c] = (a + b + d + e) >> 3;
`else
            exp_img[r*(IMG_W/2)+c] = max2(max2(a, b), max2(d, e)) >> 1;
`endif
         end
   endtask

   // Starts from IDLE with enable low; leaves DONE with enable high.
   task automatic run_frame(input string name, input int bubble_pct);
      int n, cyc, ready_err, early_done;
      n = 0; cyc = 0; ready_err = 0; early_done = 0;
      enable = 1'b1;
      step();
      while (n < N_PIX && cyc < 5000) begin
         pix_valid = ($urandom_range(99) >= bubble_pct);
         pix_in    = 8'(img[n]);
         if (!pix_ready) ready_err++;
         if (pool_done)  early_done++;
         step();
         if (pix_valid) n++;
         cyc++;
      end
      pix_valid = 1'b0;
      check({name, " accepted"}, n, N_PIX);
      check({name, " ready_drops"}, ready_err, 0);
      check({name, " early_done"}, early_done, 0);
      check({name, " done_on_last"}, int'(pool_done), 1);
      check({name, " ready_in_done"}, int'(pix_ready), 0);
   endtask

   task automatic go_idle();
      enable = 1'b0;
      step();
   endtask

   initial begin
      vecs[0] = '{p0:10,  p1:40,  p2:30,  p3:20,  r:0,  c:0,  exp_max:20,  exp_avg:12};
      vecs[1] = '{p0:0,   p1:0,   p2:0,   p3:200, r:2,  c:4,  exp_max:100, exp_avg:25};
      vecs[2] = '{p0:255, p1:255, p2:255, p3:255, r:13, c:13, exp_max:127, exp_avg:127};
      vecs[3] = '{p0:0,   p1:0,   p2:0,   p3:1,   r:7,  c:0,  exp_max:0,   exp_avg:0};
      vecs[4] = '{p0:201, p1:7,   p2:9,   p3:3,   r:0,  c:13, exp_max:100, exp_avg:27};
      vecs[5] = '{p0:3,   p1:129, p2:1,   p3:0,   r:13, c:0,  exp_max:64,  exp_avg:16};

      reset = 1'b1; enable = 1'b0; pix_in = '0; pix_valid = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("rst pix_ready", int'(pix_ready), 0);
      check("rst pool_done", int'(pool_done), 0);
      for (int i = 0; i < N_OUT; i++) exp_img[i] = 0;
      check_array("rst elem");

      // All-white frame, no bubbles: every element saturates at 127 in both builds.
      for (int i = 0; i < N_PIX; i++) img[i] = 255;
      for (int i = 0; i < N_OUT; i++) exp_img[i] = 127;
      run_frame("white", 0);
      check_array("white elem");
      go_idle();

      // Single-window vectors on a black background.
      for (int v = 0; v < 6; v++) begin
         int base, idx;
         for (int i = 0; i < N_PIX; i++) img[i] = 0;
         base = (2*vecs[v].r)*IMG_W + 2*vecs[v].c;
         img[base]           = vecs[v].p0;
         img[base + 1]       = vecs[v].p1;
         img[base + IMG_W]   = vecs[v].p2;
         img[base + IMG_W+1] = vecs[v].p3;
         idx = vecs[v].r*(IMG_W/2) + vecs[v].c;
         for (int i = 0; i < N_OUT; i++) exp_img[i] = 0;
`ifdef POOL_AVG_EN
         exp_img[idx] = vecs[v].exp_avg;
`else
         exp_img[idx] = vecs[v].exp_max;
`endif
         run_frame($sformatf("vec%0d", v), 20);
         check($sformatf("vec%0d elem", v), int'(pooled[idx]), exp_img[idx]);
         check_array($sformatf("vec%0d arr", v));
         go_idle();
      end

      // Random frame with ~30% bubbles against the reference.
      for (int i = 0; i < N_PIX; i++) img[i] = $urandom_range(255);
      model();
      run_frame("rand", 30);
      check_array("rand elem");

      // Held in DONE: further pixels must be ignored.
      pix_valid = 1'b1; pix_in = 8'h55;
      repeat (10) step();
      pix_valid = 1'b0;
      check("hold pool_done", int'(pool_done), 1);
      check("hold pix_ready", int'(pix_ready), 0);
      check_array("hold elem");

      // Drop enable one cycle, restart: pool_done clear until the new frame ends.
      go_idle();
      check("idle pool_done", int'(pool_done), 0);
      check("idle pix_ready", int'(pix_ready), 0);
      for (int i = 0; i < N_PIX; i++) img[i] = $urandom_range(255);
      model();
      run_frame("restart", 10);
      check_array("restart elem");
      go_idle();

      // Reset after 400 accepted pixels discards the partial frame.
      begin
         int n, cyc;
         n = 0; cyc = 0;
         for (int i = 0; i < N_PIX; i++) img[i] = 255 - (i % 251);
         enable = 1'b1;
         step();
         while (n < 400 && cyc < 3000) begin
            pix_valid = ($urandom_range(99) >= 25);
            pix_in    = 8'(img[n]);
            step();
            if (pix_valid) n++;
            cyc++;
         end
         check("mid accepted", n, 400);
         pix_valid = 1'b0; enable = 1'b0; reset = 1'b1;
         step();
         reset = 1'b0;
         check("mid pix_ready", int'(pix_ready), 0);
         check("mid pool_done", int'(pool_done), 0);
         for (int i = 0; i < N_OUT; i++) exp_img[i] = 0;
         check_array("mid elem");
      end
      for (int i = 0; i < N_PIX; i++) img[i] = $urandom_range(255);
      model();
      run_frame("post_rst", 30);
      check_array("post_rst elem");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
